// File: rtl/gray_hot_pkg.sv
// gray_hot_pkg: shared widths and Gray/one-hot conversion helpers for the encoder/decoder pair
package gray_hot_pkg;
  localparam int IDX_W = 3;
  localparam int CODE_W = 7;
  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             legal;
  } oh_t;
  function automatic logic [IDX_W-1:0] gray2bin(input logic [IDX_W-1:0] g);
    logic [IDX_W-1:0] b;
    b[IDX_W-1] = g[IDX_W-1];
    for (int i = IDX_W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
  function automatic logic [IDX_W-1:0] bin2gray(input logic [IDX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic oh_t onehot2idx(input logic [CODE_W-1:0] c);
    oh_t r;
    r.idx = '0;
    r.legal = c == '0;
    for (int i = 0; i < CODE_W; i++)
      if (c == (CODE_W'(1) << i)) begin
        r.idx = IDX_W'(i + 1);
        r.legal = 1'b1;
      end
    return r;
  endfunction
endpackage

// File: rtl/gray_hot_decode_core.sv
// gray_hot_decode_core: combinational code word to index decode with illegal-word detection
module gray_hot_decode_core
  import gray_hot_pkg::*;
#(
  parameter bit USE_GRAY = 1'b1
) (
  input  logic [CODE_W-1:0] code,
  output logic [IDX_W-1:0]  idx,
  output logic              illegal
);
  oh_t oh;
  // illegal words always decode to index 0
  always_comb begin
    oh = onehot2idx(code);
    illegal = USE_GRAY ? (code[CODE_W-1:IDX_W] != '0) : !oh.legal;
    idx = illegal ? '0 : (USE_GRAY ? gray2bin(code[IDX_W-1:0]) : oh.idx);
  end
endmodule

// File: rtl/gray_hot_decoder.sv
// gray_hot_decoder: valid/ready single-stage decoder with saturating illegal-word counter
module gray_hot_decoder
  import gray_hot_pkg::*;
#(
  parameter bit USE_GRAY = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [CODE_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_data,
  output logic              out_err,
  input  logic              out_ready,
  input  logic              err_clr,
  output logic [CNT_W-1:0]  err_count
);
  logic [IDX_W-1:0] idx;
  logic             illegal;
  logic             acc;
  logic             valid_q, valid_d, err_q, err_d;
  logic [IDX_W-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  gray_hot_decode_core #(.USE_GRAY(USE_GRAY)) u_core (
    .code   (in_data),
    .idx    (idx),
    .illegal(illegal)
  );
  assign in_ready  = !valid_q || out_ready;
  assign acc       = in_valid && in_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_err   = err_q;
  assign err_count = cnt_q;
  // load on accept, drain on handshake, otherwise hold; clear beats increment
  always_comb begin
    valid_d = acc ? 1'b1 : (out_ready ? 1'b0 : valid_q);
    data_d  = acc ? idx : data_q;
    err_d   = acc ? illegal : err_q;
    cnt_d   = err_clr ? '0 : ((acc && illegal && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q);
  end
  // output register stage and error counter
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_gray_hot_decoder.sv
// tb_gray_hot_decoder: Gray (CNT_W=2) and one-hot (CNT_W=8) decoders fed in parallel, checked against a model
module tb_gray_hot_decoder;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [6:0] in_data = '0;
  logic       out_ready = 1'b1;
  logic       err_clr = 1'b0;
  logic       g_ir, g_ov, g_oe, h_ir, h_ov, h_oe;
  logic [2:0] g_od, h_od;
  logic [1:0] g_cnt;
  logic [7:0] h_cnt;
  int checks = 0;
  int errors = 0;
  bit armed = 1'b0;
  bit mv[2];
  int md[2];
  bit me[2];
  int mc[2];
  int mmax[2] = '{3, 255};

  always #5 clk = ~clk;

  gray_hot_decoder #(.USE_GRAY(1'b1), .CNT_W(2)) dut_g (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(g_ir),
    .out_valid(g_ov), .out_data(g_od), .out_err(g_oe), .out_ready(out_ready),
    .err_clr(err_clr), .err_count(g_cnt)
  );
  gray_hot_decoder #(.USE_GRAY(1'b0), .CNT_W(8)) dut_h (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(h_ir),
    .out_valid(h_ov), .out_data(h_od), .out_err(h_oe), .out_ready(out_ready),
    .err_clr(err_clr), .err_count(h_cnt)
  );

  // returns {err, idx}: Gray by searching the encoder table, one-hot by bit counting
  function automatic logic [3:0] model_dec(input bit gray, input logic [6:0] w);
    if (gray) begin
      for (int i = 0; i < 8; i++) if (w == 7'(i ^ (i >> 1))) return {1'b0, 3'(i)};
      return 4'b1000;
    end
    if (w == '0) return 4'b0000;
    if ($countones(w) != 1) return 4'b1000;
    for (int i = 0; i < 7; i++) if (w[i]) return {1'b0, 3'(i + 1)};
    return 4'b1000;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) armed <= 1'b1;
    for (int m = 0; m < 2; m++) begin
      logic [3:0] r;
      r = model_dec(m == 0, in_data);
      if (rst) begin
        mv[m] <= 1'b0;
        md[m] <= 0;
        me[m] <= 1'b0;
        mc[m] <= 0;
      end else begin
        if (in_valid && (!mv[m] || out_ready)) begin
          mv[m] <= 1'b1;
          md[m] <= int'(r[2:0]);
          me[m] <= r[3];
        end else if (out_ready) mv[m] <= 1'b0;
        if (err_clr) mc[m] <= 0;
        else if (in_valid && (!mv[m] || out_ready) && r[3] && mc[m] < mmax[m]) mc[m] <= mc[m] + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("g_in_ready", int'(g_ir), int'(!mv[0] || out_ready));
      chk("g_out_valid", int'(g_ov), int'(mv[0]));
      chk("g_err_count", int'(g_cnt), mc[0]);
      chk("h_in_ready", int'(h_ir), int'(!mv[1] || out_ready));
      chk("h_out_valid", int'(h_ov), int'(mv[1]));
      chk("h_err_count", int'(h_cnt), mc[1]);
      if (mv[0]) begin
        chk("g_out_data", int'(g_od), md[0]);
        chk("g_out_err", int'(g_oe), int'(me[0]));
      end
      if (mv[1]) begin
        chk("h_out_data", int'(h_od), md[1]);
        chk("h_out_err", int'(h_oe), int'(me[1]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] w);
    in_valid = 1'b1;
    in_data = w;
    tick();
  endtask

  task automatic clear_counts();
    in_valid = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  logic [6:0] gseq[8] = '{7'b0000000, 7'b0000001, 7'b0000011, 7'b0000010,
                          7'b0000110, 7'b0000111, 7'b0000101, 7'b0000100};
  logic [6:0] hseq[4] = '{7'b0000000, 7'b0000001, 7'b0100000, 7'b1000000};
  int hexp[4] = '{0, 1, 6, 7};
  int sat[5] = '{1, 2, 3, 3, 3};

  initial begin
    tick();
    tick();
    rst = 1'b0;
    chk("pin_reset_valid", int'(g_ov), 0);
    chk("pin_reset_ready", int'(g_ir), 1);
    chk("pin_reset_count", int'(h_cnt), 0);
    for (int k = 0; k < 8; k++) begin
      send(gseq[k]);
      chk("pin_gray_data", int'(g_od), k);
      chk("pin_gray_err", int'(g_oe), 0);
    end
    chk("pin_gray_count", int'(g_cnt), 0);
    clear_counts();
    for (int k = 0; k < 4; k++) begin
      send(hseq[k]);
      chk("pin_hot_data", int'(h_od), hexp[k]);
    end
    send(7'b0000011);
    chk("pin_hot_bad_data", int'(h_od), 0);
    chk("pin_hot_bad_err", int'(h_oe), 1);
    chk("pin_hot_bad_count", int'(h_cnt), 1);
    clear_counts();
    send(7'b0001000);
    chk("pin_gray_bad_data", int'(g_od), 0);
    chk("pin_gray_bad_err", int'(g_oe), 1);
    chk("pin_gray_bad_count", int'(g_cnt), 1);
    clear_counts();
    for (int k = 0; k < 5; k++) begin
      send(7'b0011000);
      chk("pin_sat_count", int'(g_cnt), sat[k]);
    end
    err_clr = 1'b1;
    send(7'b0011000);
    err_clr = 1'b0;
    chk("pin_clr_prio", int'(g_cnt), 0);
    chk("pin_clr_err", int'(g_oe), 1);
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    send(7'b0000010);
    chk("pin_bp_first", int'(g_od), 3);
    send(7'b0000100);
    chk("pin_bp_ready", int'(g_ir), 0);
    chk("pin_bp_hold", int'(g_od), 3);
    tick();
    chk("pin_bp_hold2", int'(g_od), 3);
    out_ready = 1'b1;
    tick();
    chk("pin_bp_second", int'(g_od), 7);
    chk("pin_bp_valid", int'(g_ov), 1);
    in_valid = 1'b0;
    tick();
    chk("pin_bp_drain", int'(g_ov), 0);
    out_ready = 1'b0;
    send(7'b0011000);
    chk("pin_pre_rst_count", int'(g_cnt), 1);
    chk("pin_pre_rst_valid", int'(g_ov), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("pin_rst_valid", int'(g_ov), 0);
    chk("pin_rst_count", int'(g_cnt), 0);
    chk("pin_rst_ready", int'(g_ir), 1);
    out_ready = 1'b1;
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
